// File: rtl/pe_sched_pkg.sv
// Shared widths and FSM state encoding for the PE lockstep scheduler.
package pe_pkg;

   localparam int DATA_W = 16;
   localparam int FILT_W = 64;
   localparam int PSUM_W = 64;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

endpackage

// File: rtl/pe_sched_if.sv
// Job config, activation/weight streams, PE drive and result stream of pe_sched.
interface pe_sched_if #(
   parameter int NUM_PE = 4,
   parameter int CNT_W  = 8
) ();
   import pe_pkg::*;

   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CNT_W-1:0]     cfg_filt_len;
   logic [CNT_W-1:0]     cfg_num_pass;

   logic                 ifmap_valid;
   logic                 ifmap_ready;
   logic [DATA_W-1:0]    ifmap_data;

   logic                 filt_valid;
   logic                 filt_ready;
   logic [FILT_W-1:0]    filt_data;

   logic [NUM_PE-1:0]    pe_start;
   logic                 pe_clear;
   logic [DATA_W-1:0]    pe_ifmap;
   logic [FILT_W-1:0]    pe_filt;
   logic [NUM_PE-1:0]    pe_done;
   logic [PSUM_W-1:0]    pe_psum;

   logic                 psum_valid;
   logic                 psum_ready;
   logic [PSUM_W-1:0]    psum_data;

   // scheduler side
   modport master (
      input  cfg_valid, cfg_filt_len, cfg_num_pass,
      output cfg_ready,
      input  ifmap_valid, ifmap_data,
      output ifmap_ready,
      input  filt_valid, filt_data,
      output filt_ready,
      output pe_start, pe_clear, pe_ifmap, pe_filt,
      input  pe_done, pe_psum,
      output psum_valid, psum_data,
      input  psum_ready
   );

   // host / PE array side
   modport slave (
      output cfg_valid, cfg_filt_len, cfg_num_pass,
      input  cfg_ready,
      output ifmap_valid, ifmap_data,
      input  ifmap_ready,
      output filt_valid, filt_data,
      input  filt_ready,
      input  pe_start, pe_clear, pe_ifmap, pe_filt,
      output pe_done, pe_psum,
      input  psum_valid, psum_data,
      output psum_ready
   );

endinterface

// File: rtl/pe_sched.sv
// Sequences NUM_PE processing elements in lockstep: L taps per pass, P passes per job,
// then drains the PE pipeline and hands each partial sum out on the result stream.
//
// state | meaning
// IDLE  | waiting for a job configuration (cfg_ready=1)
// CLEAR | one-cycle pe_clear, tap counter zeroed
// RUN   | streams ready; a beat fires the PEs when both inputs are valid
// DRAIN | PIPE_LAT+1 cycles for the PE pipeline to settle, then psum captured
// OUT   | psum_valid held until psum_ready; next pass or job end
module pe_sched
   import pe_pkg::*;
#(
   parameter int NUM_PE   = 4,
   parameter int PIPE_LAT = 2,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   pe_sched_if.master bus,
   output logic       busy,
   output logic       job_done,
   output logic       err
);

   localparam int DRN_W = $clog2(PIPE_LAT + 2);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [DRN_W-1:0] DRN_ONE = DRN_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   npass_q, npass_d;
   logic [CNT_W-1:0]   tap_q, tap_d;
   logic [CNT_W-1:0]   pass_q, pass_d;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic [DATA_W-1:0]  ifmap_q;
   logic [FILT_W-1:0]  filt_q;
   logic [PSUM_W-1:0]  psum_q;
   logic               beat, beat_q;
   logic               err_q;
   logic               job_done_q, job_done_d;
   logic               last_tap, last_pass, drn_end, pe_bad;

   assign beat      = (state_q == S_RUN) && bus.ifmap_valid && bus.filt_valid;
   // >= rather than == so a full-scale L or P never relies on counter wrap
   assign last_tap  = (tap_q  >= (len_q   - CNT_ONE));
   assign last_pass = (pass_q >= (npass_q - CNT_ONE));
   assign drn_end   = (drn_q == '0);
   assign pe_bad    = beat_q && (bus.pe_done != {NUM_PE{1'b1}});

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      npass_d    = npass_q;
      tap_d      = tap_q;
      pass_d     = pass_q;
      drn_d      = drn_q;
      job_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cfg_valid) begin
               len_d   = (bus.cfg_filt_len == '0) ? CNT_ONE : bus.cfg_filt_len;
               npass_d = (bus.cfg_num_pass == '0) ? CNT_ONE : bus.cfg_num_pass;
               pass_d  = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            tap_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (beat) begin
               if (last_tap) begin
                  drn_d   = DRN_W'(PIPE_LAT);
                  state_d = S_DRAIN;
               end else begin
                  tap_d = tap_q + CNT_ONE;
               end
            end
         end
         S_DRAIN: begin
            if (drn_end) state_d = S_OUT;
            else         drn_d   = drn_q - DRN_ONE;
         end
         S_OUT: begin
            if (bus.psum_ready) begin
               pass_d = pass_q + CNT_ONE;
               if (last_pass) begin
                  job_done_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_CLEAR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         npass_q    <= '0;
         tap_q      <= '0;
         pass_q     <= '0;
         drn_q      <= '0;
         ifmap_q    <= '0;
         filt_q     <= '0;
         psum_q     <= '0;
         beat_q     <= 1'b0;
         err_q      <= 1'b0;
         job_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         npass_q    <= npass_d;
         tap_q      <= tap_d;
         pass_q     <= pass_d;
         drn_q      <= drn_d;
         beat_q     <= beat;
         job_done_q <= job_done_d;
         if (beat) begin
            ifmap_q <= bus.ifmap_data;
            filt_q  <= bus.filt_data;
         end
         if ((state_q == S_DRAIN) && drn_end) psum_q <= bus.pe_psum;
         if (pe_bad) err_q <= 1'b1;
      end
   end

   assign bus.cfg_ready   = (state_q == S_IDLE);
   assign bus.ifmap_ready = (state_q == S_RUN);
   assign bus.filt_ready  = (state_q == S_RUN);
   // PE operands pass straight through on a beat and otherwise hold the last beat's values
   assign bus.pe_start    = {NUM_PE{beat}};
   assign bus.pe_ifmap    = beat ? bus.ifmap_data : ifmap_q;
   assign bus.pe_filt     = beat ? bus.filt_data  : filt_q;
   assign bus.pe_clear    = (state_q == S_CLEAR);
   assign bus.psum_valid  = (state_q == S_OUT);
   assign bus.psum_data   = psum_q;

   assign busy     = (state_q != S_IDLE);
   assign job_done = job_done_q;
   assign err      = err_q | pe_bad;

endmodule

// File: tb/tb_pe_sched.sv
// Directed bench for pe_sched with a behavioural PE array (sum of operands per beat).
module tb_pe_sched;
   import pe_pkg::*;

   localparam int NUM_PE   = 4;
   localparam int PIPE_LAT = 2;
   localparam int CNT_W    = 8;

   logic clk = 1'b0;
   logic reset;
   logic busy, job_done, err;

   pe_sched_if #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) bus ();

   pe_sched #(.NUM_PE(NUM_PE), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .busy     (busy),
      .job_done (job_done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // PE array: done echoes start (masked), psum accumulates ifmap+filt per beat
   logic [NUM_PE-1:0] done_mask;
   logic [63:0]       acc;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.pe_done <= '0;
         acc         <= '0;
      end else begin
         bus.pe_done <= bus.pe_start & done_mask;
         if (bus.pe_clear)         acc <= '0;
         else if (bus.pe_start[0]) acc <= acc + 64'(bus.pe_ifmap) + bus.pe_filt;
      end
   end
   assign bus.pe_psum = acc;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   int          n_start, n_clear, n_pv, n_hs, n_done;
   int          first_st, last_st, first_pv, bad_start, unstable, bad_cfg, cyc;
   bit          err_seen, done_seen;
   logic [63:0] log_q [4];

   task automatic check_rst(input string p);
      chk({p, "_busy"},       busy,           0);
      chk({p, "_pe_start"},   bus.pe_start,   0);
      chk({p, "_pe_clear"},   bus.pe_clear,   0);
      chk({p, "_psum_valid"}, bus.psum_valid, 0);
      chk({p, "_job_done"},   job_done,       0);
      chk({p, "_err"},        err,            0);
      chk({p, "_psum_data"},  bus.psum_data,  0);
      chk({p, "_pe_ifmap"},   bus.pe_ifmap,   0);
      chk({p, "_pe_filt"},    bus.pe_filt,    0);
   endtask

   // Runs one job; alt drops filt_valid on odd cycles, hold stalls psum_ready,
   // stick keeps cfg_valid high while busy, abort>0 asserts reset after that many beats.
   task automatic run_job(input int l, input int p, input bit alt, input int hold,
                          input bit stick, input int abort);
      int          k = 0, ov = 0, bi = 0, tail = 0, poff;
      bit          pv_prev = 1'b0;
      logic [63:0] prev_d = '0;
      n_start = 0; n_clear = 0; n_pv = 0; n_hs = 0; n_done = 0;
      first_st = -1; last_st = -1; first_pv = -1;
      bad_start = 0; unstable = 0; bad_cfg = 0; cyc = 0;
      err_seen = 1'b0; done_seen = 1'b0;
      @(posedge clk); #1;
      bus.cfg_valid    = 1'b1;
      bus.cfg_filt_len = CNT_W'(l);
      bus.cfg_num_pass = CNT_W'(p);
      bus.ifmap_valid  = 1'b1;
      bus.filt_valid   = 1'b1;
      bus.ifmap_data   = 16'd1;
      bus.filt_data    = 64'd10;
      bus.psum_ready   = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         cyc++;
         if (bus.pe_start != '0) begin
            n_start++;
            if (first_st < 0) first_st = cyc;
            last_st = cyc;
            bi++;
            if (!bus.filt_valid || bus.pe_start != '1) bad_start++;
         end
         if (bus.pe_clear) begin
            n_clear++;
            bi = 0;
         end
         if (bus.psum_valid) begin
            n_pv++;
            if (first_pv < 0) first_pv = cyc;
            if (pv_prev && bus.psum_data !== prev_d) unstable++;
            if (bus.cfg_ready) bad_cfg++;
            if (bus.psum_ready) begin
               if (n_hs < 4) log_q[n_hs] = bus.psum_data;
               n_hs++;
            end
         end
         pv_prev = bus.psum_valid;
         prev_d  = bus.psum_data;
         if (job_done) begin
            n_done++;
            done_seen = 1'b1;
         end
         if (err) err_seen = 1'b1;
         if (done_seen) tail++;
         if (tail > 3) break;
         @(posedge clk); #1;
         if (abort > 0 && n_start >= abort) begin
            reset = 1'b1;
            break;
         end
         k++;
         bus.cfg_valid = stick && busy && !bus.psum_valid;
         if (stick) begin
            bus.cfg_filt_len = CNT_W'(9);
            bus.cfg_num_pass = CNT_W'(9);
         end
         bus.ifmap_valid = !done_seen;
         bus.filt_valid  = !done_seen && (!alt || (k % 2 == 0));
         poff = (n_clear > 0) ? n_clear - 1 : 0;
         bus.ifmap_data  = 16'(bi + 1 + 16 * poff);
         bus.filt_data   = 64'(10 * (bi + 1));
         if (bus.psum_valid) ov++;
         else                ov = 0;
         bus.psum_ready = (ov > hold);
      end
      if (abort == 0) chk("job_completed", done_seen, 1);
   endtask

   int quiet_bad;

   initial begin
      reset            = 1'b1;
      done_mask        = '1;
      bus.cfg_valid    = 1'b0;
      bus.cfg_filt_len = '0;
      bus.cfg_num_pass = '0;
      bus.ifmap_valid  = 1'b0;
      bus.ifmap_data   = '0;
      bus.filt_valid   = 1'b0;
      bus.filt_data    = '0;
      bus.psum_ready   = 1'b0;
      repeat (2) @(negedge clk);
      check_rst("rst");
      @(posedge clk); #1;
      reset = 1'b0;

      // L=3, P=1, always valid
      run_job(3, 1, 1'b0, 0, 1'b0, 0);
      chk("t1_beats",      n_start, 3);
      chk("t1_beat_span",  last_st - first_st, 2);
      chk("t1_pv_latency", first_pv - last_st, PIPE_LAT + 2);
      chk("t1_job_done",   n_done, 1);
      chk("t1_err",        err_seen, 0);
      chk("t1_n_psum",     n_hs, 1);
      chk("t1_psum",       log_q[0], 64'd66);

      // L=2, P=2
      run_job(2, 2, 1'b0, 0, 1'b0, 0);
      chk("t2_clears",   n_clear, 2);
      chk("t2_beats",    n_start, 4);
      chk("t2_n_psum",   n_hs, 2);
      chk("t2_psum0",    log_q[0], 64'd33);
      chk("t2_psum1",    log_q[1], 64'd65);
      chk("t2_job_done", n_done, 1);

      // L=4, filt_valid alternating
      run_job(4, 1, 1'b1, 0, 1'b0, 0);
      chk("t3_beats",     n_start, 4);
      chk("t3_bad_start", bad_start, 0);
      chk("t3_psum",      log_q[0], 64'd110);

      // psum_ready stalled 10 cycles, cfg_valid held high while busy
      run_job(2, 1, 1'b0, 10, 1'b1, 0);
      chk("t4_pv_cycles", n_pv, 11);
      chk("t4_unstable",  unstable, 0);
      chk("t4_cfg_ready", bad_cfg, 0);
      chk("t4_beats",     n_start, 2);
      chk("t4_psum",      log_q[0], 64'd33);
      chk("t4_job_done",  n_done, 1);

      // PE 3 never reports done
      done_mask = 4'b0111;
      run_job(2, 1, 1'b0, 0, 1'b0, 0);
      done_mask = '1;
      chk("t5_err_seen",  err_seen, 1);
      chk("t5_err_end",   err, 1);
      repeat (5) @(negedge clk);
      chk("t5_err_sticky", err, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("t5_err_reset", err, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // reset mid-RUN, then L=0/P=0
      run_job(5, 1, 1'b0, 0, 1'b0, 2);
      #1;
      check_rst("abort");
      @(posedge clk); #1;
      check_rst("abort_hold");
      reset           = 1'b0;
      bus.cfg_valid   = 1'b0;
      bus.ifmap_valid = 1'b0;
      bus.filt_valid  = 1'b0;
      bus.psum_ready  = 1'b1;
      quiet_bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.psum_valid || job_done || busy) quiet_bad++;
      end
      chk("abort_quiet", quiet_bad, 0);
      run_job(0, 0, 1'b0, 0, 1'b0, 0);
      chk("t6_beats",     n_start, 1);
      chk("t6_n_psum",    n_hs, 1);
      chk("t6_psum",      log_q[0], 64'd11);
      chk("t6_job_done",  n_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_sched.md
PE_SCHED -- requirements
Module: pe_sched

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, meaning number of PEs sequenced in lockstep.
REQ-002 SHALL have parameter PIPE_LAT, default 2, meaning PE multiplier pipeline depth in cycles.
REQ-003 SHALL have parameter CNT_W, default 8, meaning tap and pass counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid  in  1  and cfg_ready  out  1  job-configuration handshake.
REQ-007 SHALL have port cfg_filt_len  in  CNT_W  taps per pass (L); and cfg_num_pass  in  CNT_W  passes per job (P).
REQ-008 SHALL have port ifmap_valid  in  1, ifmap_ready  out  1, ifmap_data  in  16  activation stream.
REQ-009 SHALL have port filt_valid  in  1, filt_ready  out  1, filt_data  in  64  weight stream.
REQ-010 SHALL have port pe_start  out  NUM_PE, pe_clear  out  1, pe_ifmap  out  16, pe_filt  out  64  PE drive.
REQ-011 SHALL have port pe_done  in  NUM_PE, pe_psum  in  64  PE status and final partial sum.
REQ-012 SHALL have port psum_valid  out  1, psum_ready  in  1, psum_data  out  64  result stream.
REQ-013 SHALL have port busy  out  1, job_done  out  1, err  out  1  status.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, OUT.
REQ-015 SHALL assert cfg_ready only in IDLE; on cfg_valid&&cfg_ready, latch L and P (a value of 0 is latched as 1) and go to CLEAR.
REQ-016 CLEAR SHALL last exactly one cycle with pe_clear=1, zero the tap counter, then go to RUN.
REQ-017 In RUN, ifmap_ready and filt_ready SHALL both equal 1; a beat occurs only when ifmap_valid&&filt_valid in the same cycle.
REQ-018 On a beat, pe_start SHALL be all-ones for that cycle, with pe_ifmap/pe_filt equal to that cycle's ifmap_data/filt_data; otherwise pe_start=0 and pe_ifmap/pe_filt hold their last values.
REQ-019 When only one of ifmap_valid/filt_valid is high, no data SHALL be consumed and the tap counter SHALL hold.
REQ-020 After the L-th beat, the FSM SHALL go to DRAIN, and ready signals SHALL drop the following cycle.
REQ-021 DRAIN SHALL last exactly PIPE_LAT+1 cycles, then capture pe_psum into psum_data and go to OUT.
REQ-022 In OUT, psum_valid=1 and psum_data SHALL be held stable until psum_ready; on the handshake, increment the pass counter.
REQ-023 After the handshake, the FSM SHALL go to CLEAR if the pass count < P, otherwise pulse job_done for one cycle and return to IDLE.
REQ-024 In the cycle after each beat, if pe_done != all-ones, err SHALL set; err is sticky until reset.
REQ-025 busy SHALL equal 1 in every state except IDLE.
REQ-026 The counters SHALL saturate-compare (no wrap-around), so that L=P=2^CNT_W-1 completes correctly.
REQ-027 cfg_valid outside IDLE SHALL be ignored, with no latching and no state effect.

Reset
REQ-028 While reset=1, FSM=IDLE, counters=0, and pe_start, pe_clear, psum_valid, job_done, err, busy=0.
REQ-029 While reset=1, psum_data, pe_ifmap and pe_filt SHALL be 0.
REQ-030 Reset asserted mid-job SHALL abandon the job immediately, with no job_done and no psum_valid afterwards.

Structure
REQ-031 State encoding, DATA_W=16, FILT_W=64 and PSUM_W=64 SHALL live in shared package pe_pkg.
REQ-032 No sub-module is required; the counters and FSM SHALL be implemented inline.

Verification
REQ-033 Test: L=3, P=1, both streams always valid, psum_ready=1, pe_done echoes pe_start -> 3 consecutive pe_start pulses, psum_valid 4 cycles after the last beat, one job_done, err=0.
REQ-034 Test: L=2, P=2 -> pe_clear pulses twice, two psum outputs each matching pe_psum at capture, one job_done after the second.
REQ-035 Test: filt_valid low on alternate cycles with L=4 -> exactly 4 beats, and no pe_start on cycles missing filt_valid.
REQ-036 Test: psum_ready held low for 10 cycles in OUT -> psum_valid and psum_data stable, cfg_ready=0 throughout.
REQ-037 Test: pe_done=4'b0111 after a beat -> err=1 and stays 1 through job end until reset.
REQ-038 Test: reset mid-RUN, then cfg L=0, P=0 -> all outputs 0, then a single-beat, single-pass job completes.
